// File: rtl/plusarg_writer_if.sv
// Request/character-stream bundle for plusarg_writer.
// The master side issues report requests and sinks the ASCII byte stream;
// the slave side (the writer) accepts requests and produces the bytes.
interface plusarg_writer_if #(
   parameter int WIDTH = 1
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_value;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_bits;
   logic             busy;

   modport master (
      output req_valid, req_value, out_ready,
      input  req_ready, out_valid, out_bits, busy
   );

   modport slave (
      input  req_valid, req_value, out_ready,
      output req_ready, out_valid, out_bits, busy
   );
endinterface

// File: rtl/plusarg_writer.sv
// plusarg_writer: for every accepted request, streams the ASCII record
//   KEY '=' <NDIG lowercase hex digits, MSB first> '\n'
// one byte per out_valid/out_ready transfer. All outputs are registered;
// the next character is prepared on the same edge that retires the
// current one, so a sink holding out_ready high sees one byte per cycle.
module plusarg_writer #(
   parameter int                   KEY_LEN = 4,
   // Default is "borked" cut down to its first KEY_LEN characters
   // (left-padded with NUL bytes if KEY_LEN exceeds six).
   parameter logic [8*KEY_LEN-1:0] KEY     =
      (8*KEY_LEN)'(48'h626f726b6564 >> ((KEY_LEN < 6) ? 8*(6-KEY_LEN) : 0)),
   parameter int                   WIDTH   = 1
) (
   input logic              i_clock,
   input logic              i_reset,
   plusarg_writer_if.slave  bus
);

   // Number of hex digits and the zero-extended value width they cover.
   localparam int NDIG  = (WIDTH + 3) / 4;
   localparam int HEXW  = 4 * NDIG;
   // One index counter serves both the KEY and HEX phases.
   localparam int MAXC  = (KEY_LEN > NDIG) ? KEY_LEN : NDIG;
   localparam int IDX_W = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [IDX_W-1:0] KEY_LAST = IDX_W'(KEY_LEN - 1);
   localparam logic [IDX_W-1:0] HEX_LAST = IDX_W'(NDIG - 1);

   localparam logic [7:0] CH_EQ = 8'h3d;
   localparam logic [7:0] CH_NL = 8'h0a;

   typedef enum logic [2:0] {
      S_IDLE,
      S_KEY,
      S_EQ,
      S_HEX,
      S_NL
   } state_t;

   state_t           r_state;
   logic [IDX_W-1:0] r_idx;
   logic [WIDTH-1:0] r_value;
   logic             r_out_valid;
   logic [7:0]       r_out_bits;
   logic             r_req_ready;

   logic             w_req_fire;
   logic             w_out_fire;
   logic [IDX_W-1:0] w_idx_inc;
   logic [HEXW-1:0]  w_value_ext;
   logic [7:0]       w_key_nxt;
   logic [7:0]       w_hex_nxt;
   logic [7:0]       w_hex_first;

   // Map one nibble to its lowercase ASCII hex digit.
   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      if (n < 4'd10)
         return 8'h30 + {4'h0, n};
      else
         return 8'h57 + {4'h0, n};   // 0x57 + 10 = 'a'
   endfunction

   // req_ready is a register that is high only in IDLE, so it never
   // depends combinationally on req_valid or out_ready.
   assign w_req_fire  = bus.req_valid && r_req_ready;
   assign w_out_fire  = r_out_valid && bus.out_ready;
   assign w_idx_inc   = r_idx + IDX_W'(1);
   assign w_value_ext = HEXW'(r_value);
   assign w_hex_first = hex_ascii(w_value_ext[HEXW-1 -: 4]);

   // Key character that follows the one currently presented.
   always_comb begin
      w_key_nxt = 8'h00;
      for (int i = 0; i < KEY_LEN; i++) begin
         if (IDX_W'(i) == w_idx_inc)
            w_key_nxt = KEY[8*(KEY_LEN-1-i) +: 8];
      end
   end

   // Hex digit that follows the one currently presented (MSB first).
   always_comb begin
      w_hex_nxt = 8'h00;
      for (int j = 0; j < NDIG; j++) begin
         if (IDX_W'(j) == w_idx_inc)
            w_hex_nxt = hex_ascii(w_value_ext[4*(NDIG-1-j) +: 4]);
      end
   end

   // Record FSM: advances only on a byte transfer and registers the next
   // byte, the valid flag and the request-ready flag alongside the state.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_value     <= '0;
         r_out_valid <= 1'b0;
         r_out_bits  <= 8'h00;
         r_req_ready <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req_fire) begin
                  r_value     <= bus.req_value;
                  r_state     <= S_KEY;
                  r_idx       <= '0;
                  r_out_valid <= 1'b1;
                  r_out_bits  <= KEY[8*KEY_LEN-1 -: 8];
                  r_req_ready <= 1'b0;
               end
            end

            S_KEY: begin
               if (w_out_fire) begin
                  if (r_idx == KEY_LAST) begin
                     r_state    <= S_EQ;
                     r_idx      <= '0;
                     r_out_bits <= CH_EQ;
                  end else begin
                     r_idx      <= w_idx_inc;
                     r_out_bits <= w_key_nxt;
                  end
               end
            end

            S_EQ: begin
               if (w_out_fire) begin
                  r_state    <= S_HEX;
                  r_idx      <= '0;
                  r_out_bits <= w_hex_first;
               end
            end

            S_HEX: begin
               if (w_out_fire) begin
                  if (r_idx == HEX_LAST) begin
                     r_state    <= S_NL;
                     r_idx      <= '0;
                     r_out_bits <= CH_NL;
                  end else begin
                     r_idx      <= w_idx_inc;
                     r_out_bits <= w_hex_nxt;
                  end
               end
            end

            S_NL: begin
               if (w_out_fire) begin
                  r_state     <= S_IDLE;
                  r_idx       <= '0;
                  r_out_valid <= 1'b0;
                  r_out_bits  <= 8'h00;
                  r_req_ready <= 1'b1;
               end
            end

            default: begin
               r_state     <= S_IDLE;
               r_idx       <= '0;
               r_out_valid <= 1'b0;
               r_out_bits  <= 8'h00;
               r_req_ready <= 1'b1;
            end
         endcase
      end
   end

   assign bus.req_ready = r_req_ready;
   assign bus.busy      = !r_req_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_bits  = r_out_bits;

endmodule

// File: tb/tb_plusarg_writer.sv
// Bench for plusarg_writer: three instances ("max"/10-bit, "v"/1-bit and
// the default key with 64 bits) share one clock and one reset. Expected
// byte streams come from a string-building reference model.
module tb_plusarg_writer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   plusarg_writer_if #(.WIDTH(10)) ifa ();
   plusarg_writer_if #(.WIDTH(1))  ifb ();
   plusarg_writer_if #(.WIDTH(64)) ifc ();

   plusarg_writer #(.KEY_LEN(3), .KEY("max"), .WIDTH(10)) u_a (
      .i_clock(clk), .i_reset(rst), .bus(ifa));
   plusarg_writer #(.KEY_LEN(1), .KEY("v"), .WIDTH(1)) u_b (
      .i_clock(clk), .i_reset(rst), .bus(ifb));
   plusarg_writer #(.WIDTH(64)) u_c (
      .i_clock(clk), .i_reset(rst), .bus(ifc));

   // Per-instance drive/observe arrays so one task can exercise any DUT.
   logic [2:0]  rv;
   logic [2:0]  ordy;
   logic [63:0] rval [3];
   logic [2:0]  rr, ov, bsy;
   logic [7:0]  ob [3];

   assign ifa.req_valid = rv[0];
   assign ifb.req_valid = rv[1];
   assign ifc.req_valid = rv[2];
   assign ifa.req_value = rval[0][9:0];
   assign ifb.req_value = rval[1][0:0];
   assign ifc.req_value = rval[2];
   assign ifa.out_ready = ordy[0];
   assign ifb.out_ready = ordy[1];
   assign ifc.out_ready = ordy[2];
   assign rr  = {ifc.req_ready, ifb.req_ready, ifa.req_ready};
   assign ov  = {ifc.out_valid, ifb.out_valid, ifa.out_valid};
   assign bsy = {ifc.busy,      ifb.busy,      ifa.busy};
   assign ob[0] = ifa.out_bits;
   assign ob[1] = ifb.out_bits;
   assign ob[2] = ifc.out_bits;

   // Reference model: the record as a string of bytes.
   logic [7:0] exp_q[$];
   function automatic void model(input string key, input int ndig, input logic [63:0] v);
      int nib;
      exp_q.delete();
      for (int i = 0; i < key.len(); i++) exp_q.push_back(key[i]);
      exp_q.push_back(8'h3d);
      for (int d = ndig - 1; d >= 0; d--) begin
         nib = int'((v >> (4 * d)) & 64'hf);
         exp_q.push_back(8'((nib < 10) ? (48 + nib) : (87 + nib)));
      end
      exp_q.push_back(8'h0a);
   endfunction

   // One complete record on DUT d, optionally with random backpressure.
   // Starts and ends just after a rising edge with the DUT idle.
   task automatic run(input int d, input logic [63:0] v, input bit bp,
                      input string key, input int ndig, input string nm);
      int idx = 0;
      int cyc = 0;
      bit stalled = 1'b0;
      logic [7:0] held = 8'h00;
      model(key, ndig, v);
      rv[d] = 1'b1; rval[d] = v; ordy[d] = 1'b1;
      @(negedge clk);
      tests++;
      if (rr[d] !== 1'b1) begin
         fails++;
         $display("FAIL %s req_ready before fire: got %b want 1", nm, rr[d]);
      end
      @(posedge clk); #1;
      rv[d] = 1'b0; rval[d] = {$urandom, $urandom};
      while (idx < exp_q.size() && cyc < 500) begin
         ordy[d] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bp && ($urandom_range(0, 3) == 0)) rv[d] = ~rv[d];
         @(negedge clk);
         if (stalled) begin
            tests++;
            if (ob[d] !== held) begin
               fails++;
               $display("FAIL %s stall stability at byte %0d: got %h want %h", nm, idx, ob[d], held);
            end
         end
         tests++;
         if (ov[d] !== 1'b1 || bsy[d] !== 1'b1 || rr[d] !== 1'b0) begin
            fails++;
            $display("FAIL %s handshake at byte %0d: valid/busy/ready got %b%b%b want 110",
                     nm, idx, ov[d], bsy[d], rr[d]);
         end
         if (ov[d] === 1'b1 && ordy[d]) begin
            tests++;
            if (ob[d] !== exp_q[idx]) begin
               fails++;
               $display("FAIL %s byte %0d: got %h want %h", nm, idx, ob[d], exp_q[idx]);
            end
            idx++;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            held = ob[d];
         end
         cyc++;
         @(posedge clk); #1;
      end
      rv[d] = 1'b0; ordy[d] = 1'b1;
      tests++;
      if (idx != exp_q.size()) begin
         fails++;
         $display("FAIL %s record length: got %0d bytes want %0d", nm, idx, exp_q.size());
      end
      if (!bp) begin
         tests++;
         if (cyc != exp_q.size()) begin
            fails++;
            $display("FAIL %s record cycles: got %0d want %0d", nm, cyc, exp_q.size());
         end
      end
      @(negedge clk);
      tests++;
      if (rr[d] !== 1'b1 || ov[d] !== 1'b0 || bsy[d] !== 1'b0 || ob[d] !== 8'h00) begin
         fails++;
         $display("FAIL %s idle after NL: ready/valid/busy got %b%b%b bits %h want 100 bits 00",
                  nm, rr[d], ov[d], bsy[d], ob[d]);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; rv = 3'b111; ordy = 3'b111;
      for (int d = 0; d < 3; d++) rval[d] = {$urandom, $urandom};
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         tests++;
         if (ov[d] !== 1'b0 || ob[d] !== 8'h00 || rr[d] !== 1'b1 || bsy[d] !== 1'b0) begin
            fails++;
            $display("FAIL reset_state dut%0d: valid/bits/ready/busy got %b/%h/%b/%b want 0/00/1/0",
                     d, ov[d], ob[d], rr[d], bsy[d]);
         end
      end
      @(posedge clk); #1;
      rst = 1'b0; rv = 3'b000;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         tests++;
         if (ov[d] !== 1'b0 || rr[d] !== 1'b1) begin
            fails++;
            $display("FAIL reset_req_ignored dut%0d: valid/ready got %b/%b want 0/1", d, ov[d], rr[d]);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_max();
      run(0, 64'h2a5, 1'b0, "max", 3, "max_2a5");
      for (int i = 0; i < 4; i++)
         run(0, 64'($urandom_range(0, 1023)), 1'b0, "max", 3, "max_rand");
   endtask

   task automatic test_width1();
      run(1, 64'h1, 1'b0, "v", 1, "w1_one");
      run(1, 64'h0, 1'b0, "v", 1, "w1_zero");
   endtask

   task automatic test_wide();
      run(2, 64'h0000_00ff_0000_abcd, 1'b0, "bork", 16, "wide_ff_abcd");
      run(2, {$urandom, $urandom}, 1'b0, "bork", 16, "wide_rand");
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 100; i++)
         run(0, 64'($urandom_range(0, 1023)), 1'b1, "max", 3, "bp");
   endtask

   task automatic test_reset_midrecord();
      logic [63:0] v;
      v = 64'($urandom_range(0, 1023));
      model("max", 3, v);
      rv[0] = 1'b1; rval[0] = v; ordy[0] = 1'b1;
      @(posedge clk); #1;
      rv[0] = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      @(negedge clk);
      tests++;
      if (ov[0] !== 1'b1 || ob[0] !== exp_q[5]) begin
         fails++;
         $display("FAIL midreset digit1 pending: valid/bits got %b/%h want 1/%h", ov[0], ob[0], exp_q[5]);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      tests++;
      if (ov[0] !== 1'b0 || rr[0] !== 1'b1 || ob[0] !== 8'h00) begin
         fails++;
         $display("FAIL midreset abort: valid/ready/bits got %b/%b/%h want 0/1/00", ov[0], rr[0], ob[0]);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         tests++;
         if (ov[0] !== 1'b0) begin
            fails++;
            $display("FAIL midreset quiet cycle %0d: valid got %b want 0", c, ov[0]);
         end
      end
      @(posedge clk); #1;
      run(0, 64'($urandom_range(0, 1023)), 1'b0, "max", 3, "midreset_fresh");
   endtask

   task automatic test_back_to_back();
      logic [7:0]  got[$];
      logic [7:0]  expall[$];
      int          fc[$];
      logic [63:0] fv[$];
      rv[0] = 1'b1; ordy[0] = 1'b1;
      for (int c = 0; c < 50; c++) begin
         rval[0] = 64'($urandom_range(0, 1023));
         if (c >= 37) rv[0] = 1'b0;
         @(negedge clk);
         if (rv[0] && rr[0] === 1'b1) begin
            fc.push_back(c);
            fv.push_back(rval[0]);
         end
         if (ov[0] === 1'b1) got.push_back(ob[0]);
         @(posedge clk); #1;
      end
      rv[0] = 1'b0;
      tests++;
      if (fc.size() != 5 || fc[0] != 0) begin
         fails++;
         $display("FAIL b2b fire count/first: got %0d fires first at %0d want 5 at 0",
                  fc.size(), (fc.size() > 0) ? fc[0] : -1);
      end
      for (int i = 1; i < fc.size(); i++) begin
         tests++;
         if (fc[i] - fc[i-1] != 9) begin
            fails++;
            $display("FAIL b2b spacing %0d: got %0d want 9", i, fc[i] - fc[i-1]);
         end
      end
      for (int i = 0; i < fv.size(); i++) begin
         model("max", 3, fv[i]);
         foreach (exp_q[k]) expall.push_back(exp_q[k]);
      end
      tests++;
      if (got.size() != 40 || got.size() != expall.size()) begin
         fails++;
         $display("FAIL b2b stream length: got %0d want 40 (model %0d)", got.size(), expall.size());
      end
      for (int i = 0; i < got.size() && i < expall.size(); i++) begin
         tests++;
         if (got[i] !== expall[i]) begin
            fails++;
            $display("FAIL b2b byte %0d: got %h want %h", i, got[i], expall[i]);
         end
      end
   endtask

   initial begin
      rv = 3'b000; ordy = 3'b111;
      for (int d = 0; d < 3; d++) rval[d] = 64'h0;
      test_reset();
      test_max();
      test_width1();
      test_wide();
      test_backpressure();
      test_reset_midrecord();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/plusarg_writer.md
PLUSARG_WRITER -- requirements
Module: plusarg_writer

Interface
REQ-001 Parameter KEY_LEN, default 4, number of ASCII characters in KEY; legal range 1..32.
REQ-002 Parameter KEY, default "borked" truncated to KEY_LEN bytes, packed ASCII (8*KEY_LEN bits); first character in the most-significant byte.
REQ-003 Parameter WIDTH, default 1, bit width of the reported value; legal range 1..64.
REQ-004 Derived constant NDIG = ceil(WIDTH/4), the number of hex digits emitted.
REQ-005 clock  input  1  sole clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req_valid  input  1  request to emit one record.
REQ-008 req_ready  output  1  block can accept a request.
REQ-009 req_value  input  WIDTH  value to report; sampled only on request fire.
REQ-010 out_valid  output  1  out_bits holds a valid character.
REQ-011 out_ready  input  1  downstream byte sink (e.g. UART TX) accepts the character.
REQ-012 out_bits  output  8  ASCII character.
REQ-013 busy  output  1  a record is in progress.

Function
REQ-014 Each accepted request emits exactly one record, the byte string KEY, '=', NDIG lowercase hex digits MSB-first, then 0x0A; total length is KEY_LEN+NDIG+2 bytes.
REQ-015 The request fires on a cycle with req_valid && req_ready; req_value is captured into an internal WIDTH-bit register on that edge.
REQ-016 The captured value is zero-extended to 4*NDIG bits; all NDIG digits are always emitted, with no leading-zero suppression.
REQ-017 Digit encoding: 0-9 map to 0x30-0x39; a-f map to 0x61-0x66.
REQ-018 FSM states: IDLE, KEY, EQ, HEX, NL.
REQ-019 IDLE transitions to KEY on request fire.
REQ-020 KEY transitions to EQ on the fire of character index KEY_LEN-1.
REQ-021 EQ transitions to HEX on fire.
REQ-022 HEX transitions to NL on the fire of digit NDIG-1.
REQ-023 NL transitions to IDLE on fire.
REQ-024 A single index counter, sized for max(KEY_LEN, NDIG), counts characters within the KEY and HEX states; it clears on each state entry.
REQ-025 Every state advances only on an output fire (out_valid && out_ready); with out_ready held high, one byte transfers per cycle.
REQ-026 out_valid is 1 in the KEY, EQ, HEX and NL states and 0 in IDLE.
REQ-027 out_bits is stable while out_valid && !out_ready.
REQ-028 out_bits is 0x00 in IDLE.
REQ-029 req_ready is 1 only in IDLE.
REQ-030 req_ready does not depend combinationally on req_valid or out_ready.
REQ-031 busy = !req_ready.
REQ-032 Latency: the first byte (KEY[0]) is valid in the cycle after request fire.
REQ-033 With out_ready held high, the record completes in KEY_LEN+NDIG+2 cycles, and req_ready returns to 1 in the cycle after the NL fire.
REQ-034 Back-to-back requests: the minimum spacing between request fires is KEY_LEN+NDIG+3 cycles; no bubble is required beyond the return to IDLE.
REQ-035 req_value changes and req_valid toggles while busy are ignored and do not affect the record in flight.
REQ-036 An out_ready deassertion at any byte stalls the record indefinitely with no byte lost, repeated, or reordered.

Reset
REQ-037 While reset is high on a clock edge, the FSM returns to IDLE, the index clears, and the captured value clears to 0.
REQ-038 While reset is high on a clock edge, a concurrent request fire is ignored.
REQ-039 Output values after a reset edge: out_valid=0, out_bits=0x00, req_ready=1, busy=0.
REQ-040 Reset asserted mid-record aborts the record; no further bytes are emitted, and the next request produces a complete, fresh record.

Verification
REQ-041 KEY="max", KEY_LEN=3, WIDTH=10; request value 0x2A5 with out_ready=1 -> bytes 6d 61 78 3d 32 61 35 0a on 8 consecutive cycles starting the cycle after fire; req_ready=1 on the following cycle.
REQ-042 WIDTH=1, KEY="v", KEY_LEN=1; value 1 -> "v=1\n"; value 0 -> "v=0\n"; each record is 4 bytes.
REQ-043 WIDTH=64, value 0x0000_00FF_0000_ABCD -> 16 digits "000000ff0000abcd", including leading zeros.
REQ-044 Random out_ready backpressure (about 50% duty) across 100 random-value requests -> the byte stream matches the reference model exactly, and out_bits is stable during every stall.
REQ-045 Reset pulsed while HEX digit 1 is pending -> the next cycle shows out_valid=0 and req_ready=1; a new request then yields a complete, correct record.
REQ-046 req_valid held high with req_value changing every cycle -> records are spaced exactly KEY_LEN+NDIG+3 cycles apart, and each record reports the value present at its own fire cycle.
